// File: rtl/sync_barrier_ctrl.sv
// Multi-core barrier synchroniser: collects per-core arrivals,
// checks IDs, releases all participants together or flags an error.
module sync_barrier_ctrl #(
  parameter int NUM_CORES          = 4,
  parameter int SYNC_BARRIER_WIDTH = 8,
  parameter int TIMEOUT_WIDTH      = 16
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic [NUM_CORES-1:0]                    core_mask,
  input  logic [TIMEOUT_WIDTH-1:0]                timeout_cycles,
  input  logic [NUM_CORES*SYNC_BARRIER_WIDTH-1:0] sync_barrier_in,
  input  logic [NUM_CORES-1:0]                    sync_barrier_en_in,
  input  logic                                    clear_error,
  output logic [NUM_CORES-1:0]                    sync_enable,
  output logic [SYNC_BARRIER_WIDTH-1:0]           barrier_id_out,
  output logic                                    busy,
  output logic                                    error,
  output logic [1:0]                              error_code
);

  localparam int N  = NUM_CORES;
  localparam int W  = SYNC_BARRIER_WIDTH;
  localparam int TW = TIMEOUT_WIDTH;

  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_ID   = 2'b01;
  localparam logic [1:0] ERR_DUP  = 2'b10;
  localparam logic [1:0] ERR_TMO  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE,
    S_COLLECT,
    S_RELEASE,
    S_ERROR
  } state_t;

  state_t         state_q, state_d;
  logic [N-1:0]   mask_q, mask_d;
  logic [N-1:0]   arrived_q, arrived_d;
  logic [N-1:0]   sync_en_q, sync_en_d;
  logic [W-1:0]   id_q, id_d;
  logic [TW-1:0]  cnt_q, cnt_d;
  logic           busy_q, busy_d;
  logic           err_q, err_d;
  logic [1:0]     code_q, code_d;

  logic           idle;
  logic [N-1:0]   mask_eff;
  logic [N-1:0]   valid;
  logic [W-1:0]   first_id;
  logic [W-1:0]   ref_id;
  logic           mismatch;
  logic           dup;
  logic           complete;
  logic [TW-1:0]  cnt_inc;
  logic           timed_out;

  assign idle     = (state_q == S_IDLE);
  assign mask_eff = idle ? core_mask : mask_q;
  assign valid    = sync_barrier_en_in & mask_eff;

  // ID of the lowest-index valid arrival this cycle
  always_comb begin
    first_id = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (valid[i]) first_id = sync_barrier_in[i*W +: W];
    end
  end

  assign ref_id = idle ? first_id : id_q;

  // any valid arrival carrying an ID other than the reference
  always_comb begin
    mismatch = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (valid[i] && (sync_barrier_in[i*W +: W] != ref_id))
        mismatch = 1'b1;
    end
  end

  assign dup       = |(valid & arrived_q);
  assign complete  = ((arrived_q | valid) == mask_q);
  assign cnt_inc   = (&cnt_q) ? cnt_q : cnt_q + TW'(1);
  assign timed_out = (timeout_cycles != '0) &&
                     (cnt_inc == timeout_cycles);

  // next-state and next-output decode
  always_comb begin
    state_d   = state_q;
    mask_d    = mask_q;
    arrived_d = arrived_q;
    id_d      = id_q;
    cnt_d     = cnt_q;
    code_d    = code_q;
    sync_en_d = '0;
    unique case (state_q)
      S_IDLE: begin
        if (|valid) begin
          mask_d = core_mask;
          id_d   = first_id;
          cnt_d  = '0;
          if (mismatch) begin
            state_d = S_ERROR;
            code_d  = ERR_ID;
          end else if (valid == core_mask) begin
            state_d   = S_RELEASE;
            arrived_d = valid;
            sync_en_d = core_mask;
          end else begin
            state_d   = S_COLLECT;
            arrived_d = valid;
          end
        end
      end
      S_COLLECT: begin
        cnt_d = cnt_inc;
        if (mismatch) begin
          state_d = S_ERROR;
          code_d  = ERR_ID;
        end else if (dup) begin
          state_d = S_ERROR;
          code_d  = ERR_DUP;
        end else if (complete) begin
          state_d   = S_RELEASE;
          arrived_d = arrived_q | valid;
          sync_en_d = mask_q;
        end else if (timed_out) begin
          state_d = S_ERROR;
          code_d  = ERR_TMO;
        end else begin
          arrived_d = arrived_q | valid;
        end
      end
      S_RELEASE: begin
        state_d   = S_IDLE;
        arrived_d = '0;
      end
      S_ERROR: begin
        if (clear_error) begin
          state_d   = S_IDLE;
          arrived_d = '0;
          cnt_d     = '0;
          code_d    = ERR_NONE;
        end
      end
    endcase
    busy_d = (state_d != S_IDLE);
    err_d  = (state_d == S_ERROR);
  end

  // state and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      mask_q    <= '0;
      arrived_q <= '0;
      id_q      <= '0;
      cnt_q     <= '0;
      code_q    <= ERR_NONE;
      sync_en_q <= '0;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      mask_q    <= mask_d;
      arrived_q <= arrived_d;
      id_q      <= id_d;
      cnt_q     <= cnt_d;
      code_q    <= code_d;
      sync_en_q <= sync_en_d;
      busy_q    <= busy_d;
      err_q     <= err_d;
    end
  end

  assign sync_enable    = sync_en_q;
  assign barrier_id_out = id_q;
  assign busy           = busy_q;
  assign error          = err_q;
  assign error_code     = code_q;

endmodule

// File: tb/tb_sync_barrier_ctrl.sv
// Bench for sync_barrier_ctrl: directed scenarios then random
// traffic, all compared against a behavioural barrier model.
module tb_sync_barrier_ctrl;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int TW = 16;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   core_mask;
  logic [TW-1:0]  timeout_cycles;
  logic [N*W-1:0] sync_barrier_in;
  logic [N-1:0]   sync_barrier_en_in;
  logic           clear_error;
  logic [N-1:0]   sync_enable;
  logic [W-1:0]   barrier_id_out;
  logic           busy;
  logic           error;
  logic [1:0]     error_code;

  always #5 clk = ~clk;

  sync_barrier_ctrl #(
    .NUM_CORES(N), .SYNC_BARRIER_WIDTH(W), .TIMEOUT_WIDTH(TW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .core_mask(core_mask),
    .timeout_cycles(timeout_cycles),
    .sync_barrier_in(sync_barrier_in),
    .sync_barrier_en_in(sync_barrier_en_in),
    .clear_error(clear_error),
    .sync_enable(sync_enable),
    .barrier_id_out(barrier_id_out),
    .busy(busy),
    .error(error),
    .error_code(error_code)
  );

  int vectors     = 0;
  int checks      = 0;
  int miscompares = 0;

  // model: a barrier is either absent, gathering, releasing or faulted
  bit           gathering, releasing, faulted;
  logic [N-1:0] m_mask, m_seen, m_sync;
  logic [W-1:0] m_bid;
  logic [1:0]   m_code;
  int           m_wait;

  function automatic logic [W-1:0] id_of(int i);
    return sync_barrier_in[i*W +: W];
  endfunction

  task automatic set_id(int i, logic [W-1:0] v);
    sync_barrier_in[i*W +: W] = v;
  endtask

  task automatic set_all_ids(logic [W-1:0] v);
    for (int i = 0; i < N; i++) set_id(i, v);
  endtask

  task automatic model_next();
    logic [N-1:0] v;
    logic [W-1:0] r;
    bit           bad;
    bit           found;
    m_sync = '0;
    if (reset) begin
      gathering = 0; releasing = 0; faulted = 0;
      m_mask = '0; m_seen = '0; m_bid = '0;
      m_code = 2'b00; m_wait = 0;
      return;
    end
    if (releasing) begin
      releasing = 0;
      m_seen = '0;
    end else if (faulted) begin
      if (clear_error) begin
        faulted = 0; m_code = 2'b00;
        m_seen = '0; m_wait = 0;
      end
    end else if (!gathering) begin
      v = sync_barrier_en_in & core_mask;
      if (v != '0) begin
        found = 0; r = '0;
        for (int i = 0; i < N; i++)
          if (v[i] && !found) begin r = id_of(i); found = 1; end
        bad = 0;
        for (int i = 0; i < N; i++)
          if (v[i] && id_of(i) != r) bad = 1;
        m_mask = core_mask; m_bid = r; m_wait = 0;
        if (bad) begin
          faulted = 1; m_code = 2'b01;
        end else if (v == core_mask) begin
          releasing = 1; m_sync = core_mask; m_seen = v;
        end else begin
          gathering = 1; m_seen = v;
        end
      end
    end else begin
      v = sync_barrier_en_in & m_mask;
      bad = 0;
      for (int i = 0; i < N; i++)
        if (v[i] && id_of(i) != m_bid) bad = 1;
      m_wait = (m_wait < 65535) ? m_wait + 1 : m_wait;
      if (bad) begin
        gathering = 0; faulted = 1; m_code = 2'b01;
      end else if ((v & m_seen) != '0) begin
        gathering = 0; faulted = 1; m_code = 2'b10;
      end else if ((m_seen | v) == m_mask) begin
        gathering = 0; releasing = 1;
        m_seen = m_seen | v; m_sync = m_mask;
      end else if (timeout_cycles != 0 &&
                   m_wait == int'(timeout_cycles)) begin
        gathering = 0; faulted = 1; m_code = 2'b11;
      end else begin
        m_seen = m_seen | v;
      end
    end
  endtask

  task automatic check(string tag, logic [31:0] obs,
                       logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s at vector %0d: observed=%0h expected=%0h",
             tag, vectors, obs, exp);
    end
  endtask

  // apply current inputs across one edge, then compare
  task automatic tick();
    model_next();
    @(posedge clk);
    #1;
    vectors++;
    check("sync_enable", 32'(sync_enable), 32'(m_sync));
    check("busy", 32'(busy),
          32'(gathering | releasing | faulted));
    check("error", 32'(error), 32'(faulted));
    check("error_code", 32'(error_code), 32'(m_code));
    check("barrier_id", 32'(barrier_id_out), 32'(m_bid));
    sync_barrier_en_in = '0;
    clear_error = 1'b0;
  endtask

  task automatic idle_ticks(int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic strobe(logic [N-1:0] en);
    sync_barrier_en_in = en;
    tick();
  endtask

  task automatic clear();
    clear_error = 1'b1;
    tick();
  endtask

  initial begin
    reset = 1'b1;
    core_mask = '0;
    timeout_cycles = '0;
    sync_barrier_in = '0;
    sync_barrier_en_in = '0;
    clear_error = 1'b0;
    idle_ticks(2);
    reset = 1'b0;

    // all four cores, staggered arrivals, ID 0x05
    core_mask = 4'b1111;
    set_all_ids(8'h05);
    idle_ticks(3);
    strobe(4'b0001);
    idle_ticks(1);
    strobe(4'b0110);
    idle_ticks(2);
    strobe(4'b1000);
    idle_ticks(3);

    // sparse mask; unmasked core 1 strobe must be ignored
    core_mask = 4'b0101;
    set_id(0, 8'h07); set_id(1, 8'h09); set_id(2, 8'h07);
    strobe(4'b0001);
    strobe(4'b0010);
    idle_ticks(1);
    strobe(4'b0100);
    idle_ticks(2);

    // ID mismatch in COLLECT, hold, then clear
    core_mask = 4'b0011;
    set_id(0, 8'h01); set_id(1, 8'h02);
    strobe(4'b0001);
    strobe(4'b0010);
    idle_ticks(2);
    clear();
    idle_ticks(1);

    // simultaneous differing IDs straight out of IDLE
    strobe(4'b0011);
    clear();

    // timeout after 20 collect cycles
    timeout_cycles = 16'd20;
    set_all_ids(8'h01);
    strobe(4'b0001);
    idle_ticks(24);
    clear();
    timeout_cycles = 16'd0;

    // duplicate arrival
    strobe(4'b0001);
    strobe(4'b0001);
    clear();

    // mismatch outranks duplicate in the same cycle
    core_mask = 4'b0111;
    set_all_ids(8'h03);
    strobe(4'b0001);
    set_id(1, 8'h04);
    strobe(4'b0011);
    clear();

    // single-core mask releases directly
    core_mask = 4'b0100;
    set_all_ids(8'h2a);
    strobe(4'b0100);
    idle_ticks(2);

    // reset mid-collect, then a fresh barrier
    core_mask = 4'b0011;
    set_all_ids(8'h11);
    strobe(4'b0001);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    set_all_ids(8'h12);
    strobe(4'b0011);
    idle_ticks(2);

    // empty mask never starts; clear_error ignored outside ERROR
    core_mask = 4'b0000;
    strobe(4'b1111);
    clear();

    // timeout of one cycle
    core_mask = 4'b1100;
    timeout_cycles = 16'd1;
    strobe(4'b0100);
    idle_ticks(1);
    clear();

    // random traffic
    for (int k = 0; k < 3000; k++) begin
      logic [W-1:0] base;
      reset = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 15) == 0)
        core_mask = N'($urandom_range(0, 15));
      if ($urandom_range(0, 31) == 0)
        timeout_cycles = TW'($urandom_range(0, 8));
      base = W'($urandom_range(0, 3));
      for (int i = 0; i < N; i++)
        set_id(i, ($urandom_range(0, 11) == 0) ?
                  W'($urandom_range(0, 3)) : base);
      for (int i = 0; i < N; i++)
        sync_barrier_en_in[i] = ($urandom_range(0, 3) == 0);
      clear_error = ($urandom_range(0, 5) == 0);
      tick();
    end
    reset = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
